v_lut_walker: RTL and testbench

- Query-bus initiator for the `v` list engine. It walks every level of one product's list and streams the resulting entries out.
- A single walk request (prod_id) is accepted upstream. The block then issues one lookup per level (0, 1, 2, ...) on `v`'s lookup inputs and waits for each registered response.
- Each valid key/size entry is forwarded, and the walk ends with a completion summary.
- Sits between software/host-side consumers (snapshot, depth dump) and `v`'s lookup port.

---
 rtl/v_lut_walker.sv | 207 ++++++++++++++++++++
 tb/tb_v_lut_walker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lut_walker.sv
// v_lut_walker: walks every level of one product's list in `v` and
// streams the entries, then a completion summary.
// Ports: clk/arst_n; i_req_* / o_req_rdy walk request;
// i_busy holds off lookups; o_lut_* issue and i_lut_* response;
// o_ent_*_r entry stream; o_done_*_r walk summary.

package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [4:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [7:0]  size_t;
    typedef logic [5:0]  listsize_t;
endpackage

module v_lut_walker #(
    parameter int unsigned MAX_LEVELS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              i_req_vld,
    input  v_pkg::id_t        i_req_prod_id,
    output logic              o_req_rdy,
    input  logic              i_busy,
    output logic              o_lut_vld,
    output v_pkg::id_t        o_lut_prod_id,
    output v_pkg::level_t     o_lut_level,
    input  logic              i_lut_vld_r,
    input  v_pkg::key_t       i_lut_key,
    input  v_pkg::size_t      i_lut_size,
    input  logic              i_lut_error,
    input  v_pkg::listsize_t  i_lut_listsize,
    output logic              o_ent_vld_r,
    output v_pkg::level_t     o_ent_level_r,
    output v_pkg::key_t       o_ent_key_r,
    output v_pkg::size_t      o_ent_size_r,
    output logic              o_ent_last_r,
    output logic              o_done_vld_r,
    output v_pkg::id_t        o_done_prod_id_r,
    output v_pkg::listsize_t  o_done_count_r,
    output logic              o_done_error_r
);

    localparam int CW = $bits(v_pkg::listsize_t);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    v_pkg::id_t       prod_q,       prod_d;
    v_pkg::level_t    level_q,      level_d;
    v_pkg::listsize_t count_q,      count_d;
    logic [TW-1:0]    timer_q,      timer_d;
    logic             ent_vld_q,    ent_vld_d;
    v_pkg::level_t    ent_level_q,  ent_level_d;
    v_pkg::key_t      ent_key_q,    ent_key_d;
    v_pkg::size_t     ent_size_q,   ent_size_d;
    logic             ent_last_q,   ent_last_d;
    logic             done_vld_q,   done_vld_d;
    v_pkg::id_t       done_prod_q,  done_prod_d;
    v_pkg::listsize_t done_count_q, done_count_d;
    logic             done_err_q,   done_err_d;

    // Level compared in list-size width so level+1 cannot wrap.
    v_pkg::listsize_t lvl_ext;
    v_pkg::listsize_t lvl_inc;
    v_pkg::listsize_t cnt_inc;
    logic             is_last;

    assign lvl_ext = CW'(level_q);
    assign lvl_inc = lvl_ext + CW'(1);
    assign is_last = (lvl_inc == i_lut_listsize) ||
                     (lvl_inc == CW'(MAX_LEVELS));
    assign cnt_inc = (count_q >= CW'(MAX_LEVELS)) ?
                     count_q : count_q + CW'(1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            prod_q       <= '0;
            level_q      <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            ent_vld_q    <= 1'b0;
            ent_level_q  <= '0;
            ent_key_q    <= '0;
            ent_size_q   <= '0;
            ent_last_q   <= 1'b0;
            done_vld_q   <= 1'b0;
            done_prod_q  <= '0;
            done_count_q <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prod_q       <= prod_d;
            level_q      <= level_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            ent_vld_q    <= ent_vld_d;
            ent_level_q  <= ent_level_d;
            ent_key_q    <= ent_key_d;
            ent_size_q   <= ent_size_d;
            ent_last_q   <= ent_last_d;
            done_vld_q   <= done_vld_d;
            done_prod_q  <= done_prod_d;
            done_count_q <= done_count_d;
            done_err_q   <= done_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prod_d       = prod_q;
        level_d      = level_q;
        count_d      = count_q;
        timer_d      = timer_q;
        ent_vld_d    = 1'b0;
        ent_level_d  = ent_level_q;
        ent_key_d    = ent_key_q;
        ent_size_d   = ent_size_q;
        ent_last_d   = ent_last_q;
        done_vld_d   = 1'b0;
        done_prod_d  = done_prod_q;
        done_count_d = done_count_q;
        done_err_d   = done_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_vld) begin
                    prod_d  = i_req_prod_id;
                    level_d = '0;
                    count_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_busy) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_lut_vld_r && !i_lut_error) begin
                    ent_vld_d   = 1'b1;
                    ent_level_d = level_q;
                    ent_key_d   = i_lut_key;
                    ent_size_d  = i_lut_size;
                    ent_last_d  = is_last;
                    count_d     = cnt_inc;
                    if (is_last) begin
                        state_d      = S_DONE;
                        done_vld_d   = 1'b1;
                        done_prod_d  = prod_q;
                        done_count_d = cnt_inc;
                        done_err_d   = 1'b0;
                    end else begin
                        level_d = level_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (i_lut_vld_r) begin
                    // Error exactly at the list end is the normal stop.
                    state_d      = S_DONE;
                    done_vld_d   = 1'b1;
                    done_prod_d  = prod_q;
                    done_count_d = count_q;
                    done_err_d   = (lvl_ext != i_lut_listsize);
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_DONE;
                    done_vld_d   = 1'b1;
                    done_prod_d  = prod_q;
                    done_count_d = count_q;
                    done_err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_req_rdy = (state_q == S_IDLE);
        o_lut_vld = (state_q == S_ISSUE) && !i_busy;
    end

    assign o_lut_prod_id    = prod_q;
    assign o_lut_level      = level_q;
    assign o_ent_vld_r      = ent_vld_q;
    assign o_ent_level_r    = ent_level_q;
    assign o_ent_key_r      = ent_key_q;
    assign o_ent_size_r     = ent_size_q;
    assign o_ent_last_r     = ent_last_q;
    assign o_done_vld_r     = done_vld_q;
    assign o_done_prod_id_r = done_prod_q;
    assign o_done_count_r   = done_count_q;
    assign o_done_error_r   = done_err_q;

endmodule

// File: tb/tb_v_lut_walker.sv
// Directed bench for v_lut_walker: a two-cycle lookup responder
// plus hand-computed expectations for each walk scenario.
module tb_v_lut_walker;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              i_req_vld;
    logic              i_req_vld4;
    v_pkg::id_t        i_req_prod_id;
    logic              i_busy;
    logic              i_lut_vld_r;
    v_pkg::key_t       i_lut_key;
    v_pkg::size_t      i_lut_size;
    logic              i_lut_error;
    v_pkg::listsize_t  i_lut_listsize;

    logic              o_req_rdy,     rdy4;
    logic              o_lut_vld,     lv4;
    v_pkg::id_t        o_lut_prod_id, lp4;
    v_pkg::level_t     o_lut_level,   ll4;
    logic              o_ent_vld_r,   ev4;
    v_pkg::level_t     o_ent_level_r, el4;
    v_pkg::key_t       o_ent_key_r,   ek4;
    v_pkg::size_t      o_ent_size_r,  es4;
    logic              o_ent_last_r,  elast4;
    logic              o_done_vld_r,  dv4;
    v_pkg::id_t        o_done_prod_id_r, dp4;
    v_pkg::listsize_t  o_done_count_r,   dc4;
    logic              o_done_error_r,   de4;

    v_lut_walker u_dut (
        .clk(clk), .arst_n(arst_n),
        .i_req_vld(i_req_vld), .i_req_prod_id(i_req_prod_id),
        .o_req_rdy(o_req_rdy), .i_busy(i_busy),
        .o_lut_vld(o_lut_vld), .o_lut_prod_id(o_lut_prod_id),
        .o_lut_level(o_lut_level), .i_lut_vld_r(i_lut_vld_r),
        .i_lut_key(i_lut_key), .i_lut_size(i_lut_size),
        .i_lut_error(i_lut_error), .i_lut_listsize(i_lut_listsize),
        .o_ent_vld_r(o_ent_vld_r), .o_ent_level_r(o_ent_level_r),
        .o_ent_key_r(o_ent_key_r), .o_ent_size_r(o_ent_size_r),
        .o_ent_last_r(o_ent_last_r), .o_done_vld_r(o_done_vld_r),
        .o_done_prod_id_r(o_done_prod_id_r),
        .o_done_count_r(o_done_count_r),
        .o_done_error_r(o_done_error_r)
    );

    v_lut_walker #(.MAX_LEVELS(4)) u_dut4 (
        .clk(clk), .arst_n(arst_n),
        .i_req_vld(i_req_vld4), .i_req_prod_id(i_req_prod_id),
        .o_req_rdy(rdy4), .i_busy(i_busy),
        .o_lut_vld(lv4), .o_lut_prod_id(lp4),
        .o_lut_level(ll4), .i_lut_vld_r(i_lut_vld_r),
        .i_lut_key(i_lut_key), .i_lut_size(i_lut_size),
        .i_lut_error(i_lut_error), .i_lut_listsize(i_lut_listsize),
        .o_ent_vld_r(ev4), .o_ent_level_r(el4),
        .o_ent_key_r(ek4), .o_ent_size_r(es4),
        .o_ent_last_r(elast4), .o_done_vld_r(dv4),
        .o_done_prod_id_r(dp4), .o_done_count_r(dc4),
        .o_done_error_r(de4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // responder controls
    int sup_lvl = -1;
    int late    = 0;
    int err_lvl = -1;
    bit pend    = 1'b0;
    int fire    = 0;
    int plvl    = 0;
    int resp_n  = 0;

    // observation log
    logic [4:0]  e_lvl  [64];
    logic [15:0] e_key  [64];
    logic [7:0]  e_size [64];
    logic        e_last [64];
    int          n_ent = 0;
    int          l_lvl  [64];
    int          l_prod [64];
    int          l_cyc  [64];
    int          lut_n = 0;
    int          busy_strb = 0;
    int          done_n = 0;
    int          d_prod, d_count, d_err, d_cyc;

    always @(negedge clk) begin
        #2;
        i_lut_vld_r = 1'b0;
        i_lut_error = 1'b0;
        if (pend && cyc == fire) begin
            i_lut_vld_r = 1'b1;
            i_lut_key   = 16'(100 + plvl);
            i_lut_size  = 8'(5 + plvl);
            i_lut_error = (plvl >= int'(i_lut_listsize)) ||
                          (plvl == err_lvl);
            pend        = 1'b0;
            resp_n++;
        end
        if (o_lut_vld || lv4) begin
            if ((o_lut_vld && lv4) || i_busy) busy_strb++;
            plvl = o_lut_vld ? int'(o_lut_level) : int'(ll4);
            pend = 1'b1;
            fire = cyc + 2 + ((plvl == sup_lvl) ? late : 0);
            if (lut_n < 64) begin
                l_lvl[lut_n]  = plvl;
                l_prod[lut_n] = o_lut_vld ? int'(o_lut_prod_id) : int'(lp4);
                l_cyc[lut_n]  = cyc;
            end
            lut_n++;
        end
        if ((o_ent_vld_r || ev4) && n_ent < 64) begin
            e_lvl[n_ent]  = o_ent_vld_r ? o_ent_level_r : el4;
            e_key[n_ent]  = o_ent_vld_r ? o_ent_key_r   : ek4;
            e_size[n_ent] = o_ent_vld_r ? o_ent_size_r  : es4;
            e_last[n_ent] = o_ent_vld_r ? o_ent_last_r  : elast4;
        end
        if (o_ent_vld_r || ev4) n_ent++;
        if (o_done_vld_r || dv4) begin
            d_prod  = o_done_vld_r ? int'(o_done_prod_id_r) : int'(dp4);
            d_count = o_done_vld_r ? int'(o_done_count_r)   : int'(dc4);
            d_err   = o_done_vld_r ? int'(o_done_error_r)   : int'(de4);
            d_cyc   = cyc;
            done_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start(input int id, input bit four, output int t);
        i_req_prod_id = 8'(id);
        if (four) i_req_vld4 = 1'b1;
        else      i_req_vld  = 1'b1;
        t = cyc;
        step();
        i_req_vld  = 1'b0;
        i_req_vld4 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int i = 0;
        while (done_n == d0 && i < 80) begin
            step();
            i++;
        end
        chk({tag, "_done_seen"}, done_n - d0, 1);
    endtask

    task automatic chk_ents(input string tag, input int e0,
                            input int n, input int last_lvl);
        chk({tag, "_n_ent"}, n_ent - e0, n);
        for (int i = 0; i < n && e0 + i < 64; i++) begin
            chk($sformatf("%s_e%0d_lvl", tag, i), e_lvl[e0 + i], i);
            chk($sformatf("%s_e%0d_key", tag, i), e_key[e0 + i], 100 + i);
            chk($sformatf("%s_e%0d_size", tag, i), e_size[e0 + i], 5 + i);
            chk($sformatf("%s_e%0d_last", tag, i), e_last[e0 + i],
                (i == last_lvl) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e0, d0, l0, r0;
        arst_n = 1'b0;
        i_req_vld = 1'b0;
        i_req_vld4 = 1'b0;
        i_req_prod_id = '0;
        i_busy = 1'b0;
        i_lut_vld_r = 1'b0;
        i_lut_key = '0;
        i_lut_size = '0;
        i_lut_error = 1'b0;
        i_lut_listsize = '0;
        step();
        step();
        chk("rst_req_rdy", o_req_rdy, 1);
        chk("rst_lut_vld", o_lut_vld, 0);
        chk("rst_outs", {o_ent_vld_r, o_ent_level_r, o_ent_key_r,
                         o_ent_size_r, o_ent_last_r, o_done_vld_r,
                         o_done_prod_id_r, o_done_count_r,
                         o_done_error_r, o_lut_level, o_lut_prod_id}, 0);
        arst_n = 1'b1;
        step();
        step();

        // empty list
        i_lut_listsize = 6'd0;
        e0 = n_ent; d0 = done_n; l0 = lut_n;
        start(3, 1'b0, t);
        wait_done("empty", d0);
        chk("empty_n_ent", n_ent - e0, 0);
        chk("empty_prod", d_prod, 3);
        chk("empty_count", d_count, 0);
        chk("empty_err", d_err, 0);
        chk("empty_lut_lvl", l_lvl[l0], 0);
        chk("empty_lut_prod", l_prod[l0], 3);
        chk("empty_lat", d_cyc - t, 4);
        step();

        // three-entry list
        i_lut_listsize = 6'd3;
        e0 = n_ent; d0 = done_n; l0 = lut_n;
        start(7, 1'b0, t);
        wait_done("three", d0);
        chk_ents("three", e0, 3, 2);
        chk("three_prod", d_prod, 7);
        chk("three_count", d_count, 3);
        chk("three_err", d_err, 0);
        chk("three_lat", d_cyc - t, 10);
        step();

        // busy hold-off on level 1
        e0 = n_ent; d0 = done_n; l0 = lut_n;
        start(9, 1'b0, t);
        step(); step(); step();
        i_busy = 1'b1;
        step(); step(); step(); step();
        i_busy = 1'b0;
        wait_done("busy", d0);
        chk("busy_lut_n", lut_n - l0, 3);
        chk("busy_strobe_while_busy", busy_strb, 0);
        chk("busy_l1_lvl", l_lvl[l0 + 1], 1);
        chk("busy_l1_cyc", l_cyc[l0 + 1] - t, 8);
        chk_ents("busy", e0, 3, 2);
        chk("busy_count", d_count, 3);
        chk("busy_lat", d_cyc - t, 14);
        step();

        // timeout on level 1, late response afterwards
        sup_lvl = 1;
        late = 20;
        e0 = n_ent; d0 = done_n; l0 = lut_n; r0 = resp_n;
        start(11, 1'b0, t);
        wait_done("tmo", d0);
        chk("tmo_err", d_err, 1);
        chk("tmo_count", d_count, 1);
        chk("tmo_prod", d_prod, 11);
        chk("tmo_lat", d_cyc - t, 21);
        for (int i = 0; i < 30; i++) step();
        chk("tmo_late_driven", resp_n - r0, 2);
        chk_ents("tmo", e0, 1, -1);
        chk("tmo_no_extra_done", done_n - d0, 1);
        chk("tmo_idle_rdy", o_req_rdy, 1);
        sup_lvl = -1;
        late = 0;

        // unexpected error mid-list
        i_lut_listsize = 6'd5;
        err_lvl = 2;
        e0 = n_ent; d0 = done_n;
        start(12, 1'b0, t);
        wait_done("uerr", d0);
        chk_ents("uerr", e0, 2, -1);
        chk("uerr_err", d_err, 1);
        chk("uerr_count", d_count, 2);
        chk("uerr_lat", d_cyc - t, 10);
        err_lvl = -1;
        step();

        // MAX_LEVELS = 4 cap
        i_lut_listsize = 6'd10;
        e0 = n_ent; d0 = done_n;
        start(21, 1'b1, t);
        wait_done("cap", d0);
        chk_ents("cap", e0, 4, 3);
        chk("cap_prod", d_prod, 21);
        chk("cap_count", d_count, 4);
        chk("cap_err", d_err, 0);
        chk("cap_lat", d_cyc - t, 13);
        step();

        // reset during WAIT of level 2
        i_lut_listsize = 6'd5;
        d0 = done_n;
        start(5, 1'b0, t);
        for (int i = 0; i < 7; i++) step();
        arst_n = 1'b0;
        #1;
        chk("mrst_req_rdy", o_req_rdy, 1);
        chk("mrst_lut_vld", o_lut_vld, 0);
        chk("mrst_outs", {o_ent_vld_r, o_ent_level_r, o_ent_key_r,
                          o_ent_size_r, o_ent_last_r, o_done_vld_r,
                          o_done_prod_id_r, o_done_count_r,
                          o_done_error_r, o_lut_level, o_lut_prod_id}, 0);
        step();
        step();
        arst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("mrst_no_done", done_n - d0, 0);
        e0 = n_ent; d0 = done_n; l0 = lut_n;
        start(6, 1'b0, t);
        wait_done("post", d0);
        chk("post_first_lvl", l_lvl[l0], 0);
        chk("post_first_prod", l_prod[l0], 6);
        chk_ents("post", e0, 5, 4);
        chk("post_count", d_count, 5);
        chk("post_err", d_err, 0);
        chk("post_lat", d_cyc - t, 16);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
